// File: rtl/word_serializer.sv
// word_serializer
// Parallel-to-serial front end for the bit-serial arithmetic checkers.
// Accepts WIDTH-bit words on a valid/ready handshake and emits them one bit
// per transfer with first/last framing strobes.
// Words can follow each other with no idle cycle, and downstream backpressure
// holds everything in place.
module word_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_bit,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] PRE_LAST_IDX = CW'(WIDTH - 2);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] shreg, shreg_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic             first_q, first_next;
  logic             last_q, last_next;
  logic             accept;
  logic             xfer;

  // A word is held exactly while in SHIFT, so valid and busy are the state flop.
  assign ser_valid = (state == SHIFT);
  assign busy      = (state == SHIFT);
  assign ser_first = first_q;
  assign ser_last  = last_q;

  // The shift register is cleared whenever no word is held, so the end flop
  // gives a registered ser_bit that is also 0 whenever ser_valid is low.
  assign ser_bit = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

  // A new word can enter when idle, or on the cycle the last bit leaves.
  assign in_ready = (state == IDLE) | (last_q & ser_ready);
  assign accept   = in_valid & in_ready;
  assign xfer     = ser_valid & ser_ready;

  // Next-state and datapath: load on accept, shift on transfer, hold on stall.
  always_comb begin
    state_next = state;
    shreg_next = shreg;
    cnt_next   = cnt;
    first_next = first_q;
    last_next  = last_q;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = SHIFT;
          shreg_next = in_data;
          cnt_next   = '0;
          first_next = 1'b1;
          last_next  = 1'b0;
        end
      end
      SHIFT: begin
        if (xfer) begin
          if (last_q) begin
            if (accept) begin
              shreg_next = in_data;
              cnt_next   = '0;
              first_next = 1'b1;
              last_next  = 1'b0;
            end else begin
              state_next = IDLE;
              shreg_next = '0;
              cnt_next   = '0;
              first_next = 1'b0;
              last_next  = 1'b0;
            end
          end else begin
            if (MSB_FIRST) begin
              shreg_next = {shreg[WIDTH-2:0], 1'b0};
            end else begin
              shreg_next = {1'b0, shreg[WIDTH-1:1]};
            end
            cnt_next   = cnt + CW'(1);
            first_next = 1'b0;
            last_next  = (cnt == PRE_LAST_IDX);
          end
        end
      end
      default: begin
        state_next = IDLE;
        shreg_next = '0;
        cnt_next   = '0;
        first_next = 1'b0;
        last_next  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial word at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      cnt     <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state   <= state_next;
      shreg   <= shreg_next;
      cnt     <= cnt_next;
      first_q <= first_next;
      last_q  <= last_next;
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer
// Drives an MSB-first and an LSB-first word_serializer from the same inputs.
// Every cycle, both are compared against a word-level reference model:
// the word being held, the index of the bit being presented, and the bit
// picked straight from the word.
module tb_word_serializer;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         ser_ready;

  logic in_ready_m, ser_bit_m, ser_valid_m, ser_first_m, ser_last_m, busy_m;
  logic in_ready_l, ser_bit_l, ser_valid_l, ser_first_l, ser_last_l, busy_l;

  int n_compared;
  int n_mismatched;

  // reference model: held word, presented bit index, completed word count
  logic [W-1:0] m_word;
  int           m_idx;
  bit           m_have;
  int           m_done;

  // observed scoreboard from the MSB-first DUT
  int          obs_xfers;
  int          obs_firsts;
  int          obs_lasts;
  logic [31:0] seq_m;
  logic [31:0] seq_l;
  bit          last_accept;

  word_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_m), .ser_bit(ser_bit_m), .ser_valid(ser_valid_m),
    .ser_ready(ser_ready), .ser_first(ser_first_m), .ser_last(ser_last_m),
    .busy(busy_m)
  );

  word_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_l), .ser_bit(ser_bit_l), .ser_valid(ser_valid_l),
    .ser_ready(ser_ready), .ser_first(ser_first_l), .ser_last(ser_last_l),
    .busy(busy_l)
  );

  // free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_word     = '0;
    m_idx      = 0;
    m_have     = 1'b0;
    m_done     = 0;
    obs_xfers  = 0;
    obs_firsts = 0;
    obs_lasts  = 0;
  endtask

  task automatic clearSeq();
    seq_m = '0;
    seq_l = '0;
  endtask

  // One cycle: drive inputs after the falling edge, check every output against
  // the model, then advance the model to what the next rising edge should do.
  task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic r);
    bit   exp_ready;
    logic exp_bit_m, exp_bit_l, exp_first, exp_last;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    ser_ready = r;
    #1;
    exp_ready = !m_have || (m_idx == W - 1 && r);
    exp_bit_m = m_have ? m_word[W - 1 - m_idx] : 1'b0;
    exp_bit_l = m_have ? m_word[m_idx] : 1'b0;
    exp_first = m_have && (m_idx == 0);
    exp_last  = m_have && (m_idx == W - 1);

    checkOutput("msb_in_ready", in_ready_m, exp_ready);
    checkOutput("msb_valid", ser_valid_m, m_have);
    checkOutput("msb_busy", busy_m, m_have);
    checkOutput("msb_bit", ser_bit_m, exp_bit_m);
    checkOutput("msb_first", ser_first_m, exp_first);
    checkOutput("msb_last", ser_last_m, exp_last);
    checkOutput("lsb_in_ready", in_ready_l, exp_ready);
    checkOutput("lsb_valid", ser_valid_l, m_have);
    checkOutput("lsb_bit", ser_bit_l, exp_bit_l);
    checkOutput("lsb_first", ser_first_l, exp_first);
    checkOutput("lsb_last", ser_last_l, exp_last);

    if (ser_valid_m && r) begin
      obs_xfers++;
      obs_firsts += int'(ser_first_m);
      obs_lasts  += int'(ser_last_m);
      seq_m = {seq_m[30:0], ser_bit_m};
    end
    if (ser_valid_l && r) begin
      seq_l = {seq_l[30:0], ser_bit_l};
    end

    last_accept = v && exp_ready;
    if (m_have && r) begin
      if (m_idx == W - 1) begin
        m_have = 1'b0;
        m_done++;
      end else begin
        m_idx++;
      end
    end
    if (last_accept) begin
      m_word = d;
      m_idx  = 0;
      m_have = 1'b1;
    end
  endtask

  // Hold in_valid with a word until it is taken, within a cycle budget.
  task automatic offerUntilAccepted(input logic [W-1:0] d);
    int n;
    n = 0;
    do begin
      applyStimulus(1'b1, d, 1'b1);
      n++;
    end while (!last_accept && n < 40);
    if (!last_accept) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  // Let the held word run out with downstream always ready.
  task automatic drain();
    int n;
    n = 0;
    while (m_have && n < 40) begin
      applyStimulus(1'b0, '0, 1'b1);
      n++;
    end
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("drain_busy", busy_m, 32'd0);
  endtask

  initial begin
    logic         rv_valid;
    logic [W-1:0] rv_data;
    n_compared   = 0;
    n_mismatched = 0;
    last_accept  = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    ser_ready = 1'b0;
    modelReset();
    clearSeq();

    // reset values
    #1;
    checkOutput("rst_valid", ser_valid_m, 32'd0);
    checkOutput("rst_busy", busy_m, 32'd0);
    checkOutput("rst_bit", ser_bit_m, 32'd0);
    checkOutput("rst_first", ser_first_m, 32'd0);
    checkOutput("rst_last", ser_last_m, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // single word 8'hB4, downstream always ready
    $display("[TB] single word B4");
    clearSeq();
    applyStimulus(1'b1, 8'hB4, 1'b1);
    repeat (W + 1) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("b4_msb_seq", seq_m, 32'h0000_00B4);
    checkOutput("b4_lsb_seq", seq_l, 32'h0000_002D);

    // back-to-back 8'h03 then 8'hFF with in_valid held
    $display("[TB] back-to-back 03/FF");
    clearSeq();
    applyStimulus(1'b1, 8'h03, 1'b1);
    offerUntilAccepted(8'hFF);
    drain();
    checkOutput("b2b_msb_seq", seq_m, 32'h0000_03FF);
    checkOutput("b2b_lsb_seq", seq_l, 32'h0000_C0FF);

    // stall on the third bit of 8'hA5
    $display("[TB] stall A5");
    clearSeq();
    applyStimulus(1'b1, 8'hA5, 1'b1);
    repeat (2) applyStimulus(1'b0, '0, 1'b1);
    repeat (3) begin
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("stall_bit", ser_bit_m, 32'd1);
    end
    drain();
    checkOutput("stall_seq", seq_m, 32'h0000_00A5);
    checkOutput("stall_xfers", obs_xfers, 32'(m_done * W));

    // asynchronous reset four bits into 8'hFF
    $display("[TB] reset mid-word");
    applyStimulus(1'b1, 8'hFF, 1'b1);
    repeat (4) applyStimulus(1'b0, '0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", ser_valid_m, 32'd0);
    checkOutput("arst_busy", busy_m, 32'd0);
    checkOutput("arst_bit", ser_bit_m, 32'd0);
    checkOutput("arst_first", ser_first_m, 32'd0);
    checkOutput("arst_last", ser_last_m, 32'd0);
    checkOutput("arst_in_ready", in_ready_m, 32'd1);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    clearSeq();
    applyStimulus(1'b1, 8'h81, 1'b1);
    drain();
    checkOutput("post_rst_seq", seq_m, 32'h0000_0081);

    // 8'h55 offered mid-word, taken only on the last bit
    $display("[TB] offer mid-word");
    clearSeq();
    applyStimulus(1'b1, 8'h3C, 1'b1);
    repeat (3) applyStimulus(1'b0, '0, 1'b1);
    offerUntilAccepted(8'h55);
    drain();
    checkOutput("mid_msb_seq", seq_m, 32'h0000_3C55);
    checkOutput("mid_lsb_seq", seq_l, 32'h0000_3CAA);

    // randomized traffic with held-until-accepted upstream and random backpressure
    $display("[TB] random traffic");
    rv_valid    = 1'b0;
    rv_data     = '0;
    last_accept = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (!rv_valid || last_accept) begin
        rv_valid = ($urandom_range(0, 2) != 0);
        rv_data  = W'($urandom);
      end
      applyStimulus(rv_valid, rv_data, ($urandom_range(0, 3) != 0));
    end
    drain();

    // each word serialized exactly once with one first and one last strobe
    checkOutput("sb_xfers", obs_xfers, 32'(m_done * W));
    checkOutput("sb_firsts", obs_firsts, 32'(m_done));
    checkOutput("sb_lasts", obs_lasts, 32'(m_done));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
